// File: rtl/audio_mem_slot_if.sv
// Audio mixer fetch port plus the VRAM/TILEMEM read-slot signals of audio_mem_slot.
// The slave modport is the slot itself; master is the mixer/memory side.
interface audio_mem_slot_if #(
  parameter int VRAM_W  = 16,
  parameter int TILE_W  = 13,
  parameter int STALL_W = 16
);
  logic               audio_req_i;
  logic               audio_tile_i;
  logic [VRAM_W-1:0]  audio_addr_i;
  logic               audio_ack_o;
  logic [15:0]        audio_word_o;
  logic               vram_free_i;
  logic               vram_sel_o;
  logic [VRAM_W-1:0]  vram_addr_o;
  logic [15:0]        vram_data_i;
  logic               tile_free_i;
  logic               tile_sel_o;
  logic [TILE_W-1:0]  tile_addr_o;
  logic [15:0]        tile_data_i;
  logic [STALL_W-1:0] stall_count_o;

  modport slave (
    input  audio_req_i, audio_tile_i, audio_addr_i,
    input  vram_free_i, vram_data_i, tile_free_i, tile_data_i,
    output audio_ack_o, audio_word_o, vram_sel_o, vram_addr_o,
    output tile_sel_o, tile_addr_o, stall_count_o
  );

  modport master (
    output audio_req_i, audio_tile_i, audio_addr_i,
    output vram_free_i, vram_data_i, tile_free_i, tile_data_i,
    input  audio_ack_o, audio_word_o, vram_sel_o, vram_addr_o,
    input  tile_sel_o, tile_addr_o, stall_count_o
  );
endinterface

// File: rtl/audio_mem_slot.sv
// Steals unused VRAM/TILEMEM cycles to service one audio mixer word fetch at a time.
// Optional wait-cycle statistics: define AUDIO_MEM_STALL_STATS_EN.
package xv;
  localparam int VRAM_W = 16;
  localparam int TILE_W = 13;
endpackage

// state | meaning
// IDLE  | no request in flight, waiting for audio_req_i
// WAIT  | request latched, waiting for a free cycle on the target memory
// ISSUE | select pulse with latched address on the target memory
// READ  | memory returns data this cycle, captured into audio_word_o
// ACK   | single-cycle completion strobe to the mixer
module audio_mem_slot #(
  parameter int STALL_W = 16
) (
  input  logic            clk,
  input  logic            reset_i,
  audio_mem_slot_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;

  logic [2:0]            state;
  logic                  lat_tile;
  logic [xv::VRAM_W-1:0] lat_addr;
  logic                  ack_q;
  logic [15:0]           word_q;
  logic                  vram_sel_q;
  logic [xv::VRAM_W-1:0] vram_addr_q;
  logic                  tile_sel_q;
  logic [xv::TILE_W-1:0] tile_addr_q;
  logic                  mem_free;

  assign mem_free = lat_tile ? bus.tile_free_i : bus.vram_free_i;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      lat_tile    <= 1'b0;
      lat_addr    <= '0;
      ack_q       <= 1'b0;
      word_q      <= '0;
      vram_sel_q  <= 1'b0;
      vram_addr_q <= '0;
      tile_sel_q  <= 1'b0;
      tile_addr_q <= '0;
    end else begin
      ack_q      <= 1'b0;
      vram_sel_q <= 1'b0;
      tile_sel_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.audio_req_i && !ack_q) begin
            lat_tile <= bus.audio_tile_i;
            lat_addr <= bus.audio_addr_i;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A withdrawn request wins over a free slot so an abort never touches memory.
          if (!bus.audio_req_i) begin
            state <= S_IDLE;
          end else if (mem_free) begin
            state <= S_ISSUE;
            if (lat_tile) begin
              tile_sel_q  <= 1'b1;
              tile_addr_q <= lat_addr[xv::TILE_W-1:0];
            end else begin
              vram_sel_q  <= 1'b1;
              vram_addr_q <= lat_addr;
            end
          end
        end
        S_ISSUE: state <= S_READ;
        S_READ: begin
          word_q <= lat_tile ? bus.tile_data_i : bus.vram_data_i;
          if (bus.audio_req_i) begin
            ack_q <= 1'b1;
            state <= S_ACK;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.audio_ack_o  = ack_q;
  assign bus.audio_word_o = word_q;
  assign bus.vram_sel_o   = vram_sel_q;
  assign bus.vram_addr_o  = vram_addr_q;
  assign bus.tile_sel_o   = tile_sel_q;
  assign bus.tile_addr_o  = tile_addr_q;

`ifdef AUDIO_MEM_STALL_STATS_EN
  logic [STALL_W-1:0] stall_q;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      stall_q <= '0;
    end else if (state == S_WAIT && !mem_free && stall_q != {STALL_W{1'b1}}) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_count_o = stall_q;
`else
  assign bus.stall_count_o = '0;
`endif
endmodule

// File: tb/tb_audio_mem_slot.sv
// Directed bench for audio_mem_slot; expectations follow the macro AUDIO_MEM_STALL_STATS_EN.
module tb_audio_mem_slot;
  localparam int SW = 8;
`ifdef AUDIO_MEM_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic reset_i;
  int   checks;
  int   errors;

  audio_mem_slot_if #(.VRAM_W(16), .TILE_W(13), .STALL_W(SW)) bus ();

  audio_mem_slot #(.STALL_W(SW)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.audio_req_i  = 1'b0;
    bus.audio_tile_i = 1'b0;
    bus.audio_addr_i = 16'h0000;
    bus.vram_free_i  = 1'b0;
    bus.vram_data_i  = 16'hDEAD;
    bus.tile_free_i  = 1'b0;
    bus.tile_data_i  = 16'hDEAD;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.audio_ack_o, bus.vram_sel_o, bus.tile_sel_o, bus.audio_word_o,
         bus.vram_addr_o, bus.tile_addr_o, bus.stall_count_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b vsel=%b tsel=%b word=%h vaddr=%h taddr=%h stall=%0d, want all 0",
               bus.audio_ack_o, bus.vram_sel_o, bus.tile_sel_o, bus.audio_word_o,
               bus.vram_addr_o, bus.tile_addr_o, bus.stall_count_o);
    end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_vram_read();
    bus.audio_req_i  = 1'b1;
    bus.audio_tile_i = 1'b0;
    bus.audio_addr_i = 16'h1234;
    bus.vram_free_i  = 1'b1;
    tick();
    checks++;
    if (bus.vram_sel_o !== 1'b0 || bus.audio_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL vram_cycle1: sel=%b ack=%b, want 0 0", bus.vram_sel_o, bus.audio_ack_o);
    end
    tick();
    checks++;
    if (bus.vram_sel_o !== 1'b1 || bus.tile_sel_o !== 1'b0 || bus.vram_addr_o !== 16'h1234) begin
      errors++;
      $display("FAIL vram_issue: vsel=%b tsel=%b addr=%h, want 1 0 1234",
               bus.vram_sel_o, bus.tile_sel_o, bus.vram_addr_o);
    end
    tick();
    bus.vram_data_i = 16'hBEEF;
    checks++;
    if (bus.vram_sel_o !== 1'b0 || bus.audio_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL vram_read: sel=%b ack=%b, want 0 0", bus.vram_sel_o, bus.audio_ack_o);
    end
    tick();
    bus.vram_data_i = 16'hDEAD;
    checks++;
    if (bus.audio_ack_o !== 1'b1 || bus.audio_word_o !== 16'hBEEF) begin
      errors++;
      $display("FAIL vram_ack: ack=%b word=%h, want 1 beef", bus.audio_ack_o, bus.audio_word_o);
    end
    bus.audio_req_i = 1'b0;
    tick();
    checks++;
    if (bus.audio_ack_o !== 1'b0 || bus.audio_word_o !== 16'hBEEF || bus.stall_count_o !== '0) begin
      errors++;
      $display("FAIL vram_after: ack=%b word=%h stall=%0d, want 0 beef 0",
               bus.audio_ack_o, bus.audio_word_o, bus.stall_count_o);
    end
  endtask

  task automatic test_tile_stall();
    int bad;
    bad = 0;
    bus.audio_req_i  = 1'b1;
    bus.audio_tile_i = 1'b1;
    bus.audio_addr_i = 16'hF7FF;
    bus.tile_free_i  = 1'b0;
    bus.vram_free_i  = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 3) begin
        bus.audio_addr_i = 16'h0000;
        bus.audio_tile_i = 1'b0;
      end
      if (bus.audio_ack_o || bus.vram_sel_o || bus.tile_sel_o) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tile_wait_quiet: %0d cycles with ack/sel high, want 0", bad);
    end
    bus.tile_free_i = 1'b1;
    tick();
    checks++;
    if (bus.tile_sel_o !== 1'b1 || bus.vram_sel_o !== 1'b0 || bus.tile_addr_o !== 13'h17FF) begin
      errors++;
      $display("FAIL tile_issue: tsel=%b vsel=%b taddr=%h, want 1 0 17ff",
               bus.tile_sel_o, bus.vram_sel_o, bus.tile_addr_o);
    end
    checks++;
    if (bus.vram_addr_o !== 16'h1234) begin
      errors++;
      $display("FAIL vram_addr_hold: got %h, want 1234", bus.vram_addr_o);
    end
    tick();
    bus.tile_data_i = 16'hA5C3;
    tick();
    bus.tile_data_i = 16'hDEAD;
    checks++;
    if (bus.audio_ack_o !== 1'b1 || bus.audio_word_o !== 16'hA5C3) begin
      errors++;
      $display("FAIL tile_ack_at_14: ack=%b word=%h, want 1 a5c3", bus.audio_ack_o, bus.audio_word_o);
    end
    checks++;
    if (bus.stall_count_o !== (STATS ? SW'(10) : SW'(0))) begin
      errors++;
      $display("FAIL tile_stall_count: got %0d, want %0d", bus.stall_count_o, STATS ? 10 : 0);
    end
    bus.audio_req_i = 1'b0;
    bus.tile_free_i = 1'b0;
    bus.vram_free_i = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int bad;
    bad = 0;
    bus.audio_req_i  = 1'b1;
    bus.audio_tile_i = 1'b0;
    bus.audio_addr_i = 16'h0042;
    tick();
    tick();
    bus.audio_req_i = 1'b0;
    bus.vram_free_i = 1'b1;
    bus.tile_free_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.audio_ack_o || bus.vram_sel_o || bus.tile_sel_o) bad++;
    end
    checks++;
    if (bad != 0 || bus.vram_addr_o !== 16'h1234) begin
      errors++;
      $display("FAIL abort_no_access: bad=%0d vaddr=%h, want 0 1234", bad, bus.vram_addr_o);
    end
    checks++;
    if (bus.stall_count_o !== (STATS ? SW'(11) : SW'(0))) begin
      errors++;
      $display("FAIL abort_stall_count: got %0d, want %0d", bus.stall_count_o, STATS ? 11 : 0);
    end
    bus.audio_req_i  = 1'b1;
    bus.audio_addr_i = 16'h0055;
    tick();
    tick();
    checks++;
    if (bus.vram_sel_o !== 1'b1 || bus.vram_addr_o !== 16'h0055) begin
      errors++;
      $display("FAIL abort_then_idle: sel=%b addr=%h, want 1 0055", bus.vram_sel_o, bus.vram_addr_o);
    end
    tick();
    bus.audio_req_i = 1'b0;
    tick();
    checks++;
    if (bus.audio_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL read_req_drop_ack: ack=%b, want 0", bus.audio_ack_o);
    end
    checks++;
    if (bus.audio_word_o !== 16'hDEAD) begin
      errors++;
      $display("FAIL read_req_drop_word: word=%h, want dead", bus.audio_word_o);
    end
    tick();
  endtask

  task automatic test_reset_in_issue();
    int bad;
    bad = 0;
    bus.audio_req_i  = 1'b1;
    bus.audio_tile_i = 1'b0;
    bus.audio_addr_i = 16'h0777;
    bus.vram_free_i  = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.vram_sel_o !== 1'b1) begin
      errors++;
      $display("FAIL issue_before_reset: sel=%b, want 1", bus.vram_sel_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if ({bus.audio_ack_o, bus.vram_sel_o, bus.tile_sel_o, bus.audio_word_o,
         bus.vram_addr_o, bus.tile_addr_o, bus.stall_count_o} !== '0) begin
      errors++;
      $display("FAIL async_reset_issue: vsel=%b word=%h vaddr=%h taddr=%h stall=%0d, want all 0",
               bus.vram_sel_o, bus.audio_word_o, bus.vram_addr_o, bus.tile_addr_o, bus.stall_count_o);
    end
    bus.audio_req_i = 1'b0;
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.audio_ack_o || bus.vram_sel_o || bus.tile_sel_o) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_ack_after_reset: %0d cycles with ack/sel, want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ack, exp_vsel, exp_tsel;
    int   bad, both;
    bad  = 0;
    both = 0;
    bus.audio_req_i  = 1'b1;
    bus.audio_tile_i = 1'b0;
    bus.audio_addr_i = 16'h0010;
    bus.vram_free_i  = 1'b1;
    bus.tile_free_i  = 1'b1;
    bus.vram_data_i  = 16'h0A0A;
    bus.tile_data_i  = 16'h0B0B;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_ack  = (i == 4) || (i == 9);
      exp_vsel = (i == 2);
      exp_tsel = (i == 7);
      if (bus.vram_sel_o && bus.tile_sel_o) both++;
      if (bus.audio_ack_o !== exp_ack || bus.vram_sel_o !== exp_vsel || bus.tile_sel_o !== exp_tsel) begin
        bad++;
        $display("b2b cycle %0d: ack=%b vsel=%b tsel=%b expected %b %b %b", i,
                 bus.audio_ack_o, bus.vram_sel_o, bus.tile_sel_o, exp_ack, exp_vsel, exp_tsel);
      end
      if (i == 2) begin
        checks++;
        if (bus.vram_addr_o !== 16'h0010) begin
          errors++;
          $display("FAIL b2b_vram_addr: got %h, want 0010", bus.vram_addr_o);
        end
      end
      if (i == 4) begin
        checks++;
        if (bus.audio_word_o !== 16'h0A0A) begin
          errors++;
          $display("FAIL b2b_word1: got %h, want 0a0a", bus.audio_word_o);
        end
        bus.audio_addr_i = 16'h0011;
        bus.audio_tile_i = 1'b1;
      end
      if (i == 7) begin
        checks++;
        if (bus.tile_addr_o !== 13'h0011) begin
          errors++;
          $display("FAIL b2b_tile_addr: got %h, want 0011", bus.tile_addr_o);
        end
      end
      if (i == 9) begin
        checks++;
        if (bus.audio_word_o !== 16'h0B0B) begin
          errors++;
          $display("FAIL b2b_word2: got %h, want 0b0b", bus.audio_word_o);
        end
        bus.audio_req_i = 1'b0;
      end
    end
    checks++;
    if (bad != 0 || both != 0) begin
      errors++;
      $display("FAIL b2b_sequence: %0d bad cycles, %0d dual-select cycles, want 0 0", bad, both);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_saturate();
    int n;
    n = (1 << SW) + 5;
    bus.audio_req_i  = 1'b1;
    bus.audio_tile_i = 1'b0;
    bus.audio_addr_i = 16'h0100;
    bus.vram_free_i  = 1'b0;
    tick();
    for (int i = 0; i < n; i++) tick();
    checks++;
    if (bus.stall_count_o !== (STATS ? {SW{1'b1}} : SW'(0))) begin
      errors++;
      $display("FAIL stall_saturate: got %h, want %h", bus.stall_count_o, STATS ? {SW{1'b1}} : SW'(0));
    end
    bus.audio_req_i = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.stall_count_o !== (STATS ? {SW{1'b1}} : SW'(0))) begin
      errors++;
      $display("FAIL stall_hold: got %h after abort, want unchanged", bus.stall_count_o);
    end
    reset_i = 1'b1;
    #1;
    checks++;
    if (bus.stall_count_o !== '0) begin
      errors++;
      $display("FAIL stall_reset_clear: got %h, want 0", bus.stall_count_o);
    end
    tick();
    reset_i = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_vram_read();
    test_tile_stall();
    test_abort();
    test_reset_in_issue();
    test_back_to_back();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_mem_slot.md
AUDIO_MEM_SLOT -- requirements
Module: audio_mem_slot

Interface
REQ-001 SHALL have parameter STALL_W, default 16: width of stall counter output.
REQ-002 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have port reset_i, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port audio_req_i, input, 1: audio mixer fetch request, held high until ack.
REQ-005 SHALL have port audio_tile_i, input, 1: 1 = TILEMEM, 0 = VRAM.
REQ-006 SHALL have port audio_addr_i, input, xv::VRAM_W: word address.
REQ-007 SHALL have port audio_ack_o, output, 1: single-cycle completion strobe.
REQ-008 SHALL have port audio_word_o, output, 16: fetched word, valid when ack is high.
REQ-009 SHALL have port vram_free_i, input, 1: next VRAM cycle unused by video.
REQ-010 SHALL have port vram_sel_o, output, 1: VRAM read select.
REQ-011 SHALL have port vram_addr_o, output, xv::VRAM_W: VRAM read address.
REQ-012 SHALL have port vram_data_i, input, 16: VRAM read data.
REQ-013 SHALL have port tile_free_i, input, 1: next TILEMEM cycle unused by video.
REQ-014 SHALL have port tile_sel_o, output, 1: TILEMEM read select.
REQ-015 SHALL have port tile_addr_o, output, xv::TILE_W: TILEMEM read address.
REQ-016 SHALL have port tile_data_i, input, 16: TILEMEM read data.
REQ-017 SHALL have port stall_count_o, output, STALL_W: saturating wait-cycle count, see Configuration.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, ISSUE, READ, ACK.
REQ-019 IDLE: SHALL latch tile and address when audio_req_i=1 and audio_ack_o=0, then go to WAIT; otherwise stay in IDLE.
REQ-020 WAIT: SHALL go to ISSUE when the free input of the latched memory is 1.
REQ-021 WAIT: SHALL return to IDLE with no memory access if audio_req_i=0 (abort).
REQ-022 WAIT: otherwise SHALL stay in WAIT, indefinitely, with no timeout.
REQ-023 ISSUE: SHALL assert exactly one sel_o (the latched memory's), for one cycle, with the latched address, then go to READ.
REQ-024 READ: read data SHALL be valid this cycle (1-cycle memory latency); SHALL register it into audio_word_o, then go to ACK.
REQ-025 ACK: SHALL drive audio_ack_o=1 for exactly one cycle, then go to IDLE.
REQ-026 Minimum latency SHALL be 4 cycles, measured from the first clock edge sampling req=1 to the ack-high cycle, when free=1 in WAIT.
REQ-027 Once ISSUE is entered, the read SHALL complete; if audio_req_i=0 on the READ cycle, ack SHALL be suppressed and audio_word_o SHALL still update.
REQ-028 tile_addr_o SHALL equal audio_addr_i[xv::TILE_W-1:0]; upper bits SHALL be ignored.
REQ-029 At most one request SHALL be outstanding.
REQ-030 audio_req_i high in the cycle after ack SHALL start a new transaction from IDLE, not a duplicate of the prior one.
REQ-031 Changes to address or tile while a request is in flight SHALL be ignored.
REQ-032 vram_sel_o and tile_sel_o SHALL never be high simultaneously.
REQ-033 vram_addr_o, tile_addr_o and audio_word_o SHALL hold their last value when not selected or acked.

Reset
REQ-034 Assertion of reset_i SHALL immediately force state IDLE and clear every output to 0: ack, sel, addr, word and stall_count_o.
REQ-035 Assertion of reset_i mid-ISSUE SHALL drop sel the same instant, and no ack SHALL follow.
REQ-036 Release of reset_i SHALL take effect on the next clk edge; the first request SHALL be sampled no earlier than that edge.

Configuration
REQ-037 The macro name SHALL be AUDIO_MEM_STALL_STATS_EN.
REQ-038 With AUDIO_MEM_STALL_STATS_EN defined, stall_count_o SHALL increment by 1 on every cycle spent in WAIT with free=0.
REQ-039 With AUDIO_MEM_STALL_STATS_EN defined, stall_count_o SHALL saturate at all-ones, never wrap, and clear only on reset.
REQ-040 Without AUDIO_MEM_STALL_STATS_EN defined, stall_count_o SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-041 Scenario: VRAM req, addr=0x1234, vram_free_i=1, vram_data_i=0xBEEF -> vram_sel_o with addr 0x1234 on cycle 2, ack on cycle 4 with word 0xBEEF.
REQ-042 Scenario: tile req, addr=0xF7FF, tile_free_i=0 for 10 cycles, then 1 -> tile_addr_o=0x17FF (TILE_W=13), ack 14 cycles after req, stall_count_o=10 (macro on) or 0 (macro off).
REQ-043 Scenario: req dropped during WAIT -> no sel pulse, no ack, FSM back in IDLE next cycle.
REQ-044 Scenario: reset_i pulsed asynchronously during ISSUE -> sel low immediately, ack never asserted, all outputs 0.
REQ-045 Scenario: back-to-back requests to 0x0010 (VRAM) then 0x0011 (TILE), both free -> two acks 5+ cycles apart, correct memory selected each time, never both sels high.
REQ-046 Scenario: macro on, free=0 held for 2^STALL_W+5 cycles -> stall_count_o saturates at all-ones.
